// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and single-cycle access sequencer for a combinational-read RAM.
// Latency: grant one cycle after the request is sampled; read data valid two cycles after it.
// Backpressure: requesters hold req until gnt; one access every two cycles; requests are ignored while busy.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic                  owner, owner_nxt;   // requester being served in ACCESS
    logic                  last, last_nxt;     // most recent winner, loses the next tie
    logic                  winner;
    logic                  gnt0_nxt, gnt1_nxt;
    logic                  rvalid0_nxt, rvalid1_nxt;
    logic [DATA_WIDTH-1:0] rdata0_nxt, rdata1_nxt;
    logic [ADDR_WIDTH-1:0] ram_addr_nxt;
    logic                  ram_we_nxt;
    logic [DATA_WIDTH-1:0] ram_wdata_nxt;

    // Busy is a pure decode of the state so it drops the instant reset asserts.
    assign busy = (state == ACCESS);

    // State and every registered output; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            last      <= last_nxt;
            gnt0      <= gnt0_nxt;
            gnt1      <= gnt1_nxt;
            rvalid0   <= rvalid0_nxt;
            rvalid1   <= rvalid1_nxt;
            rdata0    <= rdata0_nxt;
            rdata1    <= rdata1_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_we    <= ram_we_nxt;
            ram_wdata <= ram_wdata_nxt;
        end
    end

    // Arbitration in IDLE, completion in ACCESS; pulses default low, data registers hold.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        last_nxt      = last;
        winner        = 1'b0;
        gnt0_nxt      = 1'b0;
        gnt1_nxt      = 1'b0;
        rvalid0_nxt   = 1'b0;
        rvalid1_nxt   = 1'b0;
        rdata0_nxt    = rdata0;
        rdata1_nxt    = rdata1;
        ram_addr_nxt  = ram_addr;
        ram_we_nxt    = 1'b0;
        ram_wdata_nxt = ram_wdata;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that did not win last time goes first.
                    winner        = (req0 && req1) ? ~last : req1;
                    state_nxt     = ACCESS;
                    owner_nxt     = winner;
                    last_nxt      = winner;
                    gnt0_nxt      = ~winner;
                    gnt1_nxt      = winner;
                    ram_we_nxt    = winner ? we1 : we0;
                    ram_addr_nxt  = winner ? addr1 : addr0;
                    ram_wdata_nxt = winner ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                state_nxt = IDLE;
                // ram_we still carries the command type during ACCESS.
                if (!ram_we) begin
                    if (owner) begin
                        rvalid1_nxt = 1'b1;
                        rdata1_nxt  = ram_rdata;
                    end else begin
                        rvalid0_nxt = 1'b1;
                        rdata0_nxt  = ram_rdata;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, we0, req1, we1;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
    logic [7:0] rdata0, rdata1, ram_wdata, ram_rdata;
    logic [2:0] ram_addr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Bench-side RAM: combinational read, write at the clock edge, plus a preload port.
    logic [7:0] mem [8] = '{default: 8'h00};
    logic       pl_en = 1'b0;
    logic [2:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    // Transaction-level model: each grant is remembered by the cycle index it occupies;
    // everything expected is derived from the distance between now and that grant.
    int         ecount  = 0;     // index of the current cycle (edges seen)
    int         g_edge  = -10;   // cycle in which the latest grant is visible
    bit         g_valid = 1'b0;
    bit         g_who   = 1'b0;
    bit         g_we    = 1'b0;
    logic [2:0] g_addr  = '0;
    logic [7:0] g_wdata = '0;
    bit         m_last  = 1'b1;
    logic [7:0] mrd0    = '0;
    logic [7:0] mrd1    = '0;
    logic [7:0] shadow [8] = '{default: 8'h00};

    always @(posedge clk or negedge rst_n) begin
        int e;
        bit w;
        if (!rst_n) begin
            g_valid <= 1'b0;
            m_last  <= 1'b1;
            mrd0    <= '0;
            mrd1    <= '0;
            g_addr  <= '0;
            g_wdata <= '0;
            g_we    <= 1'b0;
        end else begin
            e = ecount + 1;
            ecount <= e;
            if (pl_en) shadow[pl_addr] <= pl_data;
            if (g_valid && e == g_edge + 1) begin
                if (g_we) shadow[g_addr] <= g_wdata;
                else if (g_who) mrd1 <= shadow[g_addr];
                else mrd0 <= shadow[g_addr];
            end
            if ((!g_valid || e >= g_edge + 2) && (req0 || req1)) begin
                w = (req0 && req1) ? ~m_last : req1;
                g_valid <= 1'b1;
                g_edge  <= e;
                g_who   <= w;
                g_we    <= w ? we1 : we0;
                g_addr  <= w ? addr1 : addr0;
                g_wdata <= w ? wdata1 : wdata0;
                m_last  <= w;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        bit in_acc, at_end;
        if (chk_en) begin
            in_acc = g_valid && (ecount == g_edge);
            at_end = g_valid && (ecount == g_edge + 1);
            check("m_gnt0",    32'(gnt0),      32'(in_acc && !g_who));
            check("m_gnt1",    32'(gnt1),      32'(in_acc && g_who));
            check("m_busy",    32'(busy),      32'(in_acc));
            check("m_ram_we",  32'(ram_we),    32'(in_acc && g_we));
            check("m_ram_addr", 32'(ram_addr), 32'(g_addr));
            check("m_ram_wdata", 32'(ram_wdata), 32'(g_wdata));
            check("m_rvalid0", 32'(rvalid0),   32'(at_end && !g_we && !g_who));
            check("m_rvalid1", 32'(rvalid1),   32'(at_end && !g_we && g_who));
            check("m_rdata0",  32'(rdata0),    32'(mrd0));
            check("m_rdata1",  32'(rdata1),    32'(mrd1));
        end
    end

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One complete access with literal checks in C1 (grant) and C2 (completion).
    task automatic do_access(input bit port, input bit w, input logic [2:0] a,
                             input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
        @(negedge clk);
        if (port) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = wd; end
        else      begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = wd; end
        @(negedge clk);
        check($sformatf("%s_gnt", tag),   32'(port ? gnt1 : gnt0), 32'h1);
        check($sformatf("%s_other", tag), 32'(port ? gnt0 : gnt1), 32'h0);
        check($sformatf("%s_addr", tag),  32'(ram_addr), 32'(a));
        check($sformatf("%s_we", tag),    32'(ram_we),   32'(w));
        check($sformatf("%s_busy", tag),  32'(busy),     32'h1);
        if (w) check($sformatf("%s_wdata", tag), 32'(ram_wdata), 32'(wd));
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check($sformatf("%s_rvalid", tag), 32'(port ? rvalid1 : rvalid0), 32'(!w));
        check($sformatf("%s_we_off", tag), 32'(ram_we), 32'h0);
        check($sformatf("%s_idle", tag),   32'(busy),   32'h0);
        if (!w) check($sformatf("%s_rdata", tag), 32'(port ? rdata1 : rdata0), 32'(exp_rd));
    endtask

    initial begin
        logic [7:0] g0pat, g1pat;
        rst_n = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        #3 rst_n = 1'b0;
        chk_en = 1'b1;

        // Reset with random inputs: everything held at reset values.
        repeat (3) begin
            @(negedge clk);
            {req0, we0, req1, we1} = 4'($urandom);
            addr0 = 3'($urandom); addr1 = 3'($urandom);
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            check("rst_outs", 32'({gnt0, gnt1, rvalid0, rvalid1, busy, ram_we}), 32'h0);
            check("rst_data", 32'({rdata0, rdata1, ram_wdata, 5'(ram_addr)}), 32'h0);
        end
        @(negedge clk);
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_gnt", 32'({gnt0, gnt1}), 32'h0);
        end

        // Contention: both held for 8 cycles, grants alternate starting with 0.
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 3'd1; addr1 = 3'd2;
        g0pat = '0; g1pat = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g0pat[i] = gnt0;
            g1pat[i] = gnt1;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("contend_g0", 32'(g0pat), 32'h11);
        check("contend_g1", 32'(g1pat), 32'h44);

        preload(3'd3, 8'h5A);
        preload(3'd0, 8'h11);
        preload(3'd7, 8'hFF);

        do_access(1'b0, 1'b0, 3'd3, 8'h00, 8'h5A, "single_rd");
        check("model_pin_rd0", 32'(mrd0), 32'h5A);
        do_access(1'b1, 1'b1, 3'd5, 8'hC3, 8'h00, "write5");
        check("write5_rdata1_kept", 32'(rdata1), 32'h0);
        do_access(1'b0, 1'b0, 3'd5, 8'h00, 8'hC3, "readback5");
        do_access(1'b1, 1'b0, 3'd3, 8'h00, 8'h5A, "p1_rd3");
        do_access(1'b0, 1'b0, 3'd0, 8'h00, 8'h11, "bnd_rd0");
        do_access(1'b0, 1'b0, 3'd7, 8'h00, 8'hFF, "bnd_rd7");
        check("bnd_rdata1_kept", 32'(rdata1), 32'h5A);
        check("model_pin_rd1", 32'(mrd1), 32'h5A);

        // Reset in the middle of a read at address 7.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd7;
        @(negedge clk);
        check("mid_gnt0", 32'(gnt0), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_gnt0", 32'(gnt0), 32'h0);
        check("mid_rst_we",   32'(ram_we), 32'h0);
        check("mid_rst_addr", 32'(ram_addr), 32'h0);
        check("mid_rst_rd0",  32'(rdata0), 32'h0);
        req1 = 1'b1;
        @(negedge clk);
        check("mid_no_rvalid", 32'(rvalid0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_gnt0", 32'(gnt0), 32'h1);
        check("post_rst_gnt1", 32'(gnt1), 32'h0);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
